// File: rtl/pwm_prescale_gen.sv
// pwm_prescale_gen: prescaled 16-tick PWM with frame-synchronous configuration updates.
module pwm_prescale_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] div_sel,
  input  logic [3:0] duty,
  input  logic       load,
  input  logic       enable,
  output logic       tick,
  output logic       pwm,
  output logic       period_done,
  output logic       busy
);
  logic [3:0] pre_cnt, pos, duty_act, pend_duty, lim, pos_nxt, duty_nxt;
  logic [1:0] div_act, pend_div, div_nxt;
  logic       pend, run, wrap, frame_end, apply;
  always_comb begin
    lim       = 4'((5'd2 << div_act) - 5'd1);
    run       = busy & enable;
    wrap      = run & (pre_cnt == lim);
    frame_end = wrap & (pos == 4'd15);
    // config may change while idle, at the busy falling edge, or at a frame boundary
    apply     = !run | frame_end;
    div_nxt   = !apply ? div_act : load ? div_sel : pend ? pend_div : div_act;
    duty_nxt  = !apply ? duty_act : load ? duty : pend ? pend_duty : duty_act;
    pos_nxt   = !run ? 4'd0 : wrap ? pos + 4'd1 : pos;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      pos         <= '0;
      div_act     <= '0;
      duty_act    <= '0;
      pend_div    <= '0;
      pend_duty   <= '0;
      pend        <= 1'b0;
      tick        <= 1'b0;
      pwm         <= 1'b0;
      period_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy        <= enable;
      pre_cnt     <= (wrap | !run) ? 4'd0 : pre_cnt + 4'd1;
      pos         <= pos_nxt;
      tick        <= wrap;
      period_done <= frame_end;
      pwm         <= enable && (pos_nxt < duty_nxt);
      div_act     <= div_nxt;
      duty_act    <= duty_nxt;
      pend        <= !apply & (pend | load);
      if (!apply && load) begin
        pend_div  <= div_sel;
        pend_duty <= duty;
      end
    end
  end
endmodule

// File: tb/tb_pwm_prescale_gen.sv
// tb_pwm_prescale_gen: directed table plus corner sequences for pwm_prescale_gen.
module tb_pwm_prescale_gen;
  logic       clk = 1'b0, rst_n = 1'b0, load = 1'b0, enable = 1'b0;
  logic [1:0] div_sel = '0;
  logic [3:0] duty = '0;
  logic       tick, pwm, period_done, busy;
  int         total = 0, bad = 0;

  pwm_prescale_gen dut (
    .clk(clk), .rst_n(rst_n), .div_sel(div_sel), .duty(duty), .load(load),
    .enable(enable), .tick(tick), .pwm(pwm), .period_done(period_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int div;
    int d;
    int n;
    int hi;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // enable from idle and measure the first frame; returns on the first period_done sample
  task automatic restart(input string nm, input int n, input int exp_hi, input logic exp_p1);
    int ft, pdc, hi;
    logic p1, b1;
    ft = 0; pdc = 0; hi = 0; p1 = 1'b0; b1 = 1'b0;
    enable = 1'b1;
    for (int c = 1; c <= 16 * n + 1; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c == 1) begin
        p1 = pwm;
        b1 = busy;
      end
      if (tick && ft == 0) ft = c;
      if (period_done && pdc == 0) pdc = c;
      if (c <= 16 * n) hi += int'(pwm);
    end
    chk({nm, " busy1"}, b1, 1);
    chk({nm, " pwm1"}, p1, exp_p1);
    chk({nm, " first_tick"}, ft, n + 1);
    chk({nm, " first_pd"}, pdc, 16 * n + 1);
    chk({nm, " first_hi"}, hi, exp_hi);
  endtask

  // one frame starting on a period_done sample, checked against a frame model
  task automatic run_frame(input string nm, input int n, input int d, input int lo, input int ld,
                           input int lo2, input int ld2, input int exp_hi);
    int hi, err;
    hi = 0; err = 0;
    for (int off = 0; off < 16 * n; off++) begin
      if (off > 0) @(negedge clk);
      load = 1'b0;
      hi += int'(pwm);
      err += int'(pwm !== ((off / n) < d));
      err += int'(tick !== (off % n == 0));
      err += int'(period_done !== (off == 0));
      err += int'(busy !== 1'b1);
      if (off == lo) begin
        load = 1'b1;
        duty = 4'(ld);
      end
      if (off == lo2) begin
        load = 1'b1;
        duty = 4'(ld2);
      end
    end
    @(negedge clk);
    load = 1'b0;
    chk({nm, " model"}, err, 0);
    chk({nm, " hi"}, hi, exp_hi);
    chk({nm, " pd_end"}, period_done, 1);
  endtask

  task automatic idle(input int k);
    enable = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic sync_pd(input string nm);
    for (int i = 0; i < 600 && !period_done; i++) @(negedge clk);
    chk({nm, " sync"}, period_done, 1);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{0, 8, 2, 16};
    tbl[1] = '{3, 0, 16, 0};
    tbl[2] = '{1, 15, 4, 60};
    tbl[3] = '{2, 1, 8, 8};
    tbl[4] = '{0, 15, 2, 30};

    #12;
    chk("reset outs", {tick, pwm, period_done, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle outs", {tick, pwm, period_done, busy}, 0);

    foreach (tbl[i]) begin
      idle(2);
      chk($sformatf("row%0d idle", i), {tick, pwm, period_done, busy}, 0);
      div_sel = 2'(tbl[i].div);
      duty = 4'(tbl[i].d);
      load = 1'b1;
      restart($sformatf("row%0d", i), tbl[i].n, tbl[i].hi, tbl[i].d > 0);
      for (int f = 0; f < 3; f++)
        run_frame($sformatf("row%0d f%0d", i, f), tbl[i].n, tbl[i].d, -1, 0, -1, 0, tbl[i].hi);
    end

    // mid-frame load, last strobe wins, load on period_done, pins without load
    idle(2);
    div_sel = 2'd0;
    duty = 4'd4;
    load = 1'b1;
    restart("upd", 2, 8, 1);
    run_frame("upd keep", 2, 4, 6, 12, -1, 0, 8);
    run_frame("upd new", 2, 12, -1, 0, -1, 0, 24);
    run_frame("upd two", 2, 12, 3, 10, 9, 6, 24);
    run_frame("upd last", 2, 6, 31, 2, -1, 0, 12);
    duty = 4'd15;
    div_sel = 2'd3;
    run_frame("upd coin", 2, 2, -1, 0, -1, 0, 4);

    // enable dropped at pos 5 with a pending load
    duty = 4'd8;
    div_sel = 2'd0;
    load = 1'b1;
    idle(2);
    restart("drop pre", 2, 16, 1);
    for (int off = 1; off <= 10; off++) begin
      @(negedge clk);
      load = 1'b0;
      if (off == 8) begin
        load = 1'b1;
        duty = 4'd3;
      end
      if (off == 10) enable = 1'b0;
    end
    @(negedge clk);
    chk("drop outs", {tick, pwm, period_done, busy}, 0);
    repeat (3) @(negedge clk);
    chk("drop idle", {tick, pwm, period_done, busy}, 0);
    restart("drop re", 2, 6, 1);

    // asynchronous reset mid-frame with a pending load
    idle(2);
    div_sel = 2'd2;
    duty = 4'd5;
    load = 1'b1;
    restart("rst pre", 8, 40, 1);
    repeat (20) @(negedge clk);
    load = 1'b1;
    duty = 4'd9;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("rst pre pwm", {pwm, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("rst async", {tick, pwm, period_done, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    restart("rst post", 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_prescale_gen.md
PWM_PRESCALE_GEN -- requirements
Module: pwm_prescale_gen

Interface
REQ-001 Parameters: none; all widths are fixed by this document.
REQ-002 clk  in  1  single clock; all state is updated on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 div_sel  in  2  prescale select: 00 = divide by 2, 01 = divide by 4, 10 = divide by 8, 11 = divide by 16.
REQ-005 duty  in  4  PWM high count in ticks per 16-tick frame (0..15).
REQ-006 load  in  1  one-cycle strobe that captures div_sel and duty.
REQ-007 enable  in  1  run request, level-sensitive.
REQ-008 tick  out  1  registered one-clk pulse at each prescaled period.
REQ-009 pwm  out  1  registered PWM waveform.
REQ-010 period_done  out  1  registered one-clk pulse at the end of each frame.
REQ-011 busy  out  1  registered copy of enable.

Function
REQ-012 Active configuration SHALL be held in registers div_act (2 bits) and duty_act (4 bits), separate from the pins.
REQ-013 While busy = 0, a load strobe SHALL write div_act/duty_act at the same edge.
REQ-014 While busy = 1, a load strobe SHALL be held in pending registers (the last strobe wins) and applied at the edge where period_done is asserted.
REQ-015 If load and period_done coincide, the new pin values SHALL be applied at that edge.
REQ-016 The prescaler SHALL be a 4-bit counter pre_cnt that counts 0..N-1 while busy = 1, where N = 2^(div_act+1).
REQ-017 tick SHALL be asserted for exactly one cycle every N cycles.
REQ-018 The first tick SHALL occur N cycles after the edge at which busy first reads 1.
REQ-019 A 4-bit frame position pos SHALL advance by 1 at each tick edge and wrap from 15 to 0.
REQ-020 pwm SHALL equal busy AND (pos < duty_act), registered, so it changes only at tick edges or at busy transitions.
REQ-021 duty_act = 0 SHALL hold pwm low for the whole frame; duty_act = 15 SHALL give 15 of 16 ticks high.
REQ-022 period_done SHALL assert together with the tick that wraps pos from 15 to 0 (one frame = 16*N cycles).
REQ-023 busy SHALL follow enable with one cycle of latency.
REQ-024 On a busy falling edge, pre_cnt and pos SHALL be cleared, and tick, pwm and period_done SHALL be driven 0 from that edge onward.
REQ-025 Any pending load SHALL be applied immediately when busy goes to 0.
REQ-026 Re-enabling SHALL always restart at pos = 0 with the full prescale count.
REQ-027 A change of div_sel or duty pins without a load strobe SHALL have no effect.

Reset
REQ-028 rst_n low SHALL asynchronously clear pre_cnt, pos, div_act, duty_act, the pending registers and the pending flag.
REQ-029 rst_n low SHALL asynchronously drive tick, pwm, period_done and busy to 0.
REQ-030 On reset release, the first edge SHALL sample enable normally; there is no extra warm-up cycle.
REQ-031 Reset asserted mid-frame SHALL discard the frame; operation after release SHALL match operation after power-up.

Verification
REQ-032 div_sel=00, duty=8, load, then enable=1 -> tick every 2 cycles; pwm high 16 cycles then low 16 cycles; period_done every 32 cycles.
REQ-033 div_sel=11, duty=0, run 3 frames -> pwm never high; period_done exactly every 256 cycles; tick every 16 cycles.
REQ-034 div_sel=01, duty=15 -> in each 64-cycle frame pwm is high 60 cycles and low 4 cycles, with the low phase coinciding with pos=15.
REQ-035 Running with duty=4, div_sel=00; load duty=12 mid-frame -> the current frame keeps 8 high cycles; the next frame has 24 high cycles; also check load coinciding with period_done.
REQ-036 enable dropped at pos=5 -> one cycle later busy, pwm, tick are 0; on re-enable the first tick comes after N cycles and pwm restarts at pos 0.
REQ-037 rst_n pulsed low mid-frame, asynchronously between edges -> all outputs 0 immediately; div_act=00 and duty_act=0 afterwards; a pending load is lost.
